// File: rtl/affine_addr_decoder_2d.sv
// Receiving end of a 2D affine scan: checks each incoming address against the
// programmed scan, emits the decoded (x, y) per beat and halts on the first deviation.
module affine_addr_decoder_2d #(
  parameter int AW = 32,
  parameter int SW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [SW-1:0] x_stride_i,
  input  logic [AW-1:0] y_stride_i,
  input  logic [AW-1:0] x_max_i,
  input  logic [AW-1:0] y_max_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [AW-1:0] in_addr_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [AW-1:0] out_x_o,
  output logic [AW-1:0] out_y_o,
  output logic          out_last_x_o,
  output logic          out_last_frame_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [AW-1:0] err_expected_o,
  output logic [AW-1:0] err_got_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    ERROR = 2'd3
  } state_e;

  state_e        state_q, state_d;

  logic [SW-1:0] xStride_q, xStride_d;
  logic [AW-1:0] yStride_q, yStride_d;
  logic [AW-1:0] xMax_q, xMax_d;
  logic [AW-1:0] yMax_q, yMax_d;

  logic [AW-1:0] xCnt_q, xCnt_d;
  logic [AW-1:0] yCnt_q, yCnt_d;
  logic [AW-1:0] expAddr_q, expAddr_d;

  logic          outValid_q, outValid_d;
  logic [AW-1:0] outX_q, outX_d;
  logic [AW-1:0] outY_q, outY_d;
  logic          outLastX_q, outLastX_d;
  logic          outLastFrame_q, outLastFrame_d;

  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [AW-1:0] errExpected_q, errExpected_d;
  logic [AW-1:0] errGot_q, errGot_d;

  logic          inReady;
  logic          accept;
  logic          outTaken;
  logic          addrMatch;
  logic          rowEnd;
  logic          frameEnd;

  // in_ready never looks at in_valid, so upstream may wait for it before asserting valid.
  assign inReady   = (state_q == RUN) && (!outValid_q || out_ready_i);
  assign accept    = in_valid_i && inReady;
  assign outTaken  = outValid_q && out_ready_i;
  assign addrMatch = (in_addr_i == expAddr_q);
  assign rowEnd    = (xCnt_q == xMax_q);
  assign frameEnd  = rowEnd && (yCnt_q == yMax_q);

  always_comb begin
    state_d        = state_q;
    xStride_d      = xStride_q;
    yStride_d      = yStride_q;
    xMax_d         = xMax_q;
    yMax_d         = yMax_q;
    xCnt_d         = xCnt_q;
    yCnt_d         = yCnt_q;
    expAddr_d      = expAddr_q;
    outValid_d     = outValid_q;
    outX_d         = outX_q;
    outY_d         = outY_q;
    outLastX_d     = outLastX_q;
    outLastFrame_d = outLastFrame_q;
    done_d         = 1'b0;
    err_d          = err_q;
    errExpected_d  = errExpected_q;
    errGot_d       = errGot_q;

    // A taken beat frees the register; a same-cycle accept below reloads it with no bubble.
    if (outTaken) begin
      outValid_d = 1'b0;
    end

    unique case (state_q)
      IDLE, ERROR: begin
        if (start_i) begin
          xStride_d     = x_stride_i;
          yStride_d     = y_stride_i;
          xMax_d        = x_max_i;
          yMax_d        = y_max_i;
          xCnt_d        = '0;
          yCnt_d        = '0;
          expAddr_d     = '0;
          err_d         = 1'b0;
          errExpected_d = '0;
          errGot_d      = '0;
          state_d       = RUN;
        end
      end

      RUN: begin
        if (accept) begin
          if (addrMatch) begin
            outValid_d     = 1'b1;
            outX_d         = xCnt_q;
            outY_d         = yCnt_q;
            outLastX_d     = rowEnd;
            outLastFrame_d = frameEnd;
            if (!rowEnd) begin
              xCnt_d    = xCnt_q + AW'(1);
              expAddr_d = expAddr_q + AW'(xStride_q);
            end else if (!frameEnd) begin
              xCnt_d    = '0;
              yCnt_d    = yCnt_q + AW'(1);
              expAddr_d = expAddr_q + yStride_q;
            end else begin
              state_d = DRAIN;
            end
          end else begin
            err_d         = 1'b1;
            errExpected_d = expAddr_q;
            errGot_d      = in_addr_i;
            state_d       = ERROR;
          end
        end
      end

      DRAIN: begin
        if (outTaken) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      xStride_q      <= '0;
      yStride_q      <= '0;
      xMax_q         <= '0;
      yMax_q         <= '0;
      xCnt_q         <= '0;
      yCnt_q         <= '0;
      expAddr_q      <= '0;
      outValid_q     <= 1'b0;
      outX_q         <= '0;
      outY_q         <= '0;
      outLastX_q     <= 1'b0;
      outLastFrame_q <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      errExpected_q  <= '0;
      errGot_q       <= '0;
    end else begin
      state_q        <= state_d;
      xStride_q      <= xStride_d;
      yStride_q      <= yStride_d;
      xMax_q         <= xMax_d;
      yMax_q         <= yMax_d;
      xCnt_q         <= xCnt_d;
      yCnt_q         <= yCnt_d;
      expAddr_q      <= expAddr_d;
      outValid_q     <= outValid_d;
      outX_q         <= outX_d;
      outY_q         <= outY_d;
      outLastX_q     <= outLastX_d;
      outLastFrame_q <= outLastFrame_d;
      done_q         <= done_d;
      err_q          <= err_d;
      errExpected_q  <= errExpected_d;
      errGot_q       <= errGot_d;
    end
  end

  assign in_ready_o       = inReady;
  assign out_valid_o      = outValid_q;
  assign out_x_o          = outX_q;
  assign out_y_o          = outY_q;
  assign out_last_x_o     = outLastX_q;
  assign out_last_frame_o = outLastFrame_q;
  assign busy_o           = (state_q == RUN) || (state_q == DRAIN);
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign err_expected_o   = errExpected_q;
  assign err_got_o        = errGot_q;

endmodule

// File: tb/tb_affine_addr_decoder_2d.sv
// Scoreboard bench for affine_addr_decoder_2d: addresses come from a closed-form
// scan model, expected beats are queued on accept and popped by an output monitor.
module tb_affine_addr_decoder_2d;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        lx;
    logic        lf;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] xStride;
  logic [31:0] yStride;
  logic [31:0] xMax;
  logic [31:0] yMax;
  logic        inValid;
  logic        inReady;
  logic [31:0] inAddr;
  logic        outValid;
  logic        outReady;
  logic [31:0] outX;
  logic [31:0] outY;
  logic        outLastX;
  logic        outLastFrame;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] errExpected;
  logic [31:0] errGot;

  bit    randReady;
  bit    rndBit;
  bit    manualReady;
  bit    pendingDone;
  int    nChecks;
  int    nFails;
  int    cyc;
  int    doneCount;
  int    expectedDone;
  int    beatCount;
  beat_t sb[$];

  assign outReady = randReady ? rndBit : manualReady;

  always #5 clk = ~clk;

  affine_addr_decoder_2d #(.AW(32), .SW(16)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .x_stride_i      (xStride),
    .y_stride_i      (yStride),
    .x_max_i         (xMax),
    .y_max_i         (yMax),
    .in_valid_i      (inValid),
    .in_ready_o      (inReady),
    .in_addr_i       (inAddr),
    .out_valid_o     (outValid),
    .out_ready_i     (outReady),
    .out_x_o         (outX),
    .out_y_o         (outY),
    .out_last_x_o    (outLastX),
    .out_last_frame_o(outLastFrame),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err),
    .err_expected_o  (errExpected),
    .err_got_o       (errGot)
  );

  // Address of element (x, y): each row starts one row pitch after the previous one.
  function automatic logic [31:0] refAddr(input logic [15:0] xs, input logic [31:0] ys,
                                          input logic [31:0] xm, input int x, input int y);
    logic [31:0] step;
    logic [31:0] pitch;
    logic [31:0] xx;
    logic [31:0] yy;
    step  = {16'h0000, xs};
    pitch = xm * step + ys;
    xx    = 32'(x);
    yy    = 32'(y);
    return yy * pitch + xx * step;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic monitorLoop();
    beat_t e;
    forever begin
      @(negedge clk);
      if (pendingDone) begin
        check("donePulse", done, 1);
        pendingDone = 0;
      end
      if (done) doneCount++;
      if (outValid && outReady) begin
        if (sb.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpectedBeat: got x=%0h y=%0h, expected no beat", outX, outY);
        end else begin
          e = sb.pop_front();
          check("beat", {outX, outY, outLastX, outLastFrame}, {e.x, e.y, e.lx, e.lf});
          beatCount++;
          if (e.lf) pendingDone = 1;
        end
      end
    end
  endtask

  task automatic clockLoop();
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      rndBit = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic waitIdle();
    bit found;
    found = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!busy) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL idleTimeout: got busy=%0d, expected 0", busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendAddr(input logic [31:0] a, output bit ok);
    ok      = 0;
    inValid = 1'b1;
    inAddr  = a;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (inReady) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inAddr  = $urandom;
  endtask

  task automatic applyStimulus(input logic [15:0] xs, input logic [31:0] ys,
                               input logic [31:0] xm, input logic [31:0] ym,
                               input int badIdx, input logic [31:0] badXor,
                               input bit stallFirst, input bit startMid, input bit randGaps,
                               output int span);
    int          idx;
    int          firstC;
    int          lastC;
    bit          ok;
    logic [31:0] a;
    beat_t       b;
    idx    = 0;
    firstC = 0;
    lastC  = 0;
    span   = 0;
    waitIdle();
    xStride = xs;
    yStride = ys;
    xMax    = xm;
    yMax    = ym;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    xStride = $urandom;
    yStride = $urandom;
    xMax    = $urandom;
    yMax    = $urandom;
    @(negedge clk);
    check("startClearsErr", err, 0);
    check("busyAfterStart", busy, 1);
    @(posedge clk);
    #1;
    for (int y = 0; y <= int'(ym); y++) begin
      for (int x = 0; x <= int'(xm); x++) begin
        a = refAddr(xs, ys, xm, x, y);
        if (idx == badIdx) begin
          sendAddr(a ^ badXor, ok);
          check("badAccepted", ok, 1);
          @(negedge clk);
          check("errFlag", err, 1);
          check("errExpected", errExpected, a);
          check("errGot", errGot, a ^ badXor);
          check("errInReady", inReady, 0);
          check("errBusy", busy, 0);
          @(posedge clk);
          #1;
          return;
        end
        sendAddr(a, ok);
        check("acceptInTime", ok, 1);
        if (idx == 0) firstC = cyc;
        lastC = cyc;
        b.x  = 32'(x);
        b.y  = 32'(y);
        b.lx = (32'(x) == xm);
        b.lf = (32'(x) == xm) && (32'(y) == ym);
        sb.push_back(b);
        if (stallFirst && idx == 0) begin
          manualReady = 1'b0;
          repeat (3) begin
            @(negedge clk);
            check("stallInReady", inReady, 0);
            check("stallValid", outValid, 1);
            check("stallStable", {outX, outY, outLastX}, {32'd0, 32'd0, (xm == 32'd0)});
          end
          @(posedge clk);
          #1;
          manualReady = 1'b1;
        end
        if (startMid && idx == 1) begin
          xStride = $urandom;
          yStride = $urandom;
          xMax    = 32'd0;
          yMax    = 32'd0;
          start   = 1'b1;
          @(posedge clk);
          #1;
          start   = 1'b0;
        end
        if (randGaps) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        idx++;
      end
    end
    span = lastC - firstC;
    waitIdle();
    expectedDone++;
  endtask

  task automatic checkOutput(input string name);
    check({name, "Ctl"}, {outX, outY, inReady, outValid, outLastX, outLastFrame, busy, done, err}, 0);
    check({name, "Err"}, {errExpected, errGot}, 0);
  endtask

  initial begin
    int          span;
    int          b0;
    bit          ok;
    logic [31:0] rx;
    logic [31:0] ry;
    int          bad;
    rst_n       = 1'b0;
    start       = 1'b0;
    xStride     = '0;
    yStride     = '0;
    xMax        = '0;
    yMax        = '0;
    inValid     = 1'b0;
    inAddr      = '0;
    manualReady = 1'b1;
    randReady   = 1'b0;
    fork
      monitorLoop();
      clockLoop();
    join_none

    repeat (2) @(negedge clk);
    checkOutput("resetState");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(16'd4, 32'd8, 32'd2, 32'd1, -1, 32'd0, 0, 0, 0, span);
    check("oneBeatPerCycle", span, 5);

    b0 = beatCount;
    applyStimulus(16'd4, 32'd8, 32'd2, 32'd1, 2, 32'h4, 0, 0, 0, span);
    repeat (3) @(negedge clk);
    check("mismatchBeats", beatCount - b0, 2);
    check("errHeld", {err, errExpected, errGot}, {1'b1, 32'd8, 32'd12});

    applyStimulus(16'd4, 32'd8, 32'd2, 32'd1, -1, 32'd0, 0, 0, 0, span);
    applyStimulus(16'd4, 32'd8, 32'd2, 32'd1, -1, 32'd0, 1, 0, 0, span);
    applyStimulus(16'($urandom), $urandom, 32'd0, 32'd0, -1, 32'd0, 0, 0, 0, span);
    applyStimulus(16'($urandom), 32'h10, 32'd0, 32'd2, -1, 32'd0, 0, 0, 0, span);
    applyStimulus(16'hFFFF, 32'd0, 32'd1, 32'd0, -1, 32'd0, 0, 0, 0, span);
    applyStimulus(16'($urandom), 32'hFFFF_FFF0, 32'd0, 32'd1, -1, 32'd0, 0, 0, 0, span);
    applyStimulus(16'd4, 32'd8, 32'd2, 32'd1, -1, 32'd0, 0, 1, 0, span);

    waitIdle();
    xStride = 16'd1;
    yStride = 32'd1;
    xMax    = 32'd3;
    yMax    = 32'd1;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sendAddr(32'd0, ok);
    check("rstAccept", ok, 1);
    manualReady = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midFrameReset");
    sb.delete();
    pendingDone = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    manualReady = 1'b1;

    randReady = 1'b1;
    for (int f = 0; f < 20; f++) begin
      rx  = 32'($urandom_range(0, 3));
      ry  = 32'($urandom_range(0, 3));
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      applyStimulus(16'($urandom), $urandom, rx, ry, bad, 32'h1 << $urandom_range(0, 31),
                    0, 0, 1, span);
    end
    randReady = 1'b0;
    waitIdle();
    repeat (5) @(negedge clk);
    check("scoreboardEmpty", sb.size(), 0);
    check("doneCount", doneCount, expectedDone);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/affine_addr_decoder_2d.md
Name: affine_addr_decoder_2d

Overview:
- Receiving end of the 2D affine scan address stream: consumes one address per valid/ready handshake, tracks the scan the address generator must be following, and emits the decoded (x, y) coordinate per beat.
- Flags any address that deviates from the programmed scan and halts on the first deviation.
- Sits between the scan address generator (or a memory request port) and any per-pixel consumer or checker.

Parameters:
- AW, 32, address and counter width (x_max, y_max, y_stride, addresses, coordinates).
- SW, 16, x_stride width; zero-extended to AW before any arithmetic.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  latch configuration and begin a frame; honoured only in IDLE or ERROR.
- x_stride  in  SW  address increment between elements in a row.
- y_stride  in  AW  address increment from the last element of a row to the next row.
- x_max  in  AW  last x index (row length = x_max+1).
- y_max  in  AW  last y index (frame height = y_max+1).
- in_valid  in  1  in_addr is valid.
- in_ready  out  1  block accepts in_addr this cycle.
- in_addr  in  AW  incoming address.
- out_valid  out  1  decoded beat available.
- out_ready  in  1  downstream accepts the beat.
- out_x  out  AW  x index of the beat.
- out_y  out  AW  y index of the beat.
- out_last_x  out  1  beat is the last element of its row.
- out_last_frame  out  1  beat is the final element of the frame.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  one-cycle pulse when the frame completes cleanly.
- err  out  1  sticky mismatch flag.
- err_expected  out  AW  expected address at the first mismatch.
- err_got  out  AW  received address at the first mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All outputs 0 (in_ready, out_valid, out_x, out_y, both last flags, busy, done, err, err_expected, err_got).
  - Internal counters and the expected-address register are 0.
- States: IDLE, RUN, DRAIN, ERROR.
- IDLE, start=1:
  - Register x_stride, y_stride, x_max and y_max.
  - Clear x, y and the expected address to 0.
  - Go to RUN.
- Configuration inputs are ignored outside the start cycle.
- in_ready = (state==RUN) && (!out_valid || out_ready). The input is combinational from state and out_valid/out_ready only, never from in_valid.
- Accept = in_valid && in_ready.
- Latency: an accepted beat appears on out_* the next cycle. The output is a single register stage; out_valid holds and out_* are stable until out_ready.
- On accept, compare in_addr to expected:
  - Match: register out_x=x, out_y=y, out_last_x=(x==x_max), out_last_frame=(x==x_max && y==y_max); set out_valid.
  - Update when x<x_max: x+=1; expected+=zext(x_stride).
  - Update when x==x_max and y<y_max: x=0; y+=1; expected+=y_stride.
  - Update when x==x_max and y==y_max: go to DRAIN; counters are unchanged.
  - Mismatch: err=1; err_expected=expected; err_got=in_addr. No output beat is produced. Go to ERROR.
- Arithmetic is modulo 2^AW. Address wrap-around is legal and is not an error.
- DRAIN: in_ready=0. When the final beat handshakes (out_valid && out_ready), pulse done for one cycle and go to IDLE.
- ERROR:
  - in_ready=0.
  - A pending out beat still drains normally.
  - err, err_expected and err_got hold until the next start.
  - start: clear err, err_expected and err_got, reload the configuration, go to RUN. This start is honoured even if an out beat is still pending; that beat remains valid and is delivered first.
- start in RUN or DRAIN is ignored.
- x_max=0 and/or y_max=0 are legal:
  - 1-wide rows: every beat has out_last_x=1.
  - 1x1 frame: the first beat is also the last.
- Simultaneous out_ready handshake and new accept in the same cycle: the out register reloads with no bubble. Full throughput is one beat per cycle.
- rst_n asserted mid-frame: immediate return to reset values; any pending beat is discarded.

Test Plan:
- Clean frame:
  - Setup: x_max=2, y_max=1, x_stride=4, y_stride=8; feed 0,4,8,16,20,24 back-to-back with out_ready=1.
  - Required: (x,y) = (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
  - Required: out_last_x on beats 3 and 6; out_last_frame on beat 6 only.
  - Required: done pulses one cycle after beat 6 is taken; no err; one beat per cycle.
- Mismatch:
  - Setup: same configuration; feed 0,4,12.
  - Required: two beats are output; err=1, err_expected=8, err_got=12; in_ready=0.
  - Required: a new start clears err, and 0,4,8,... then decodes correctly.
- Backpressure: hold out_ready=0 for 3 cycles after the first accept.
  - Required: in_ready=0 and out_* stable while stalled.
  - Required: resuming loses or duplicates no beat; the sequence is identical to the clean frame.
- Degenerate sizes:
  - x_max=0, y_max=0, any strides: single beat of addr 0 with both last flags set, then done.
  - x_max=0, y_max=2, y_stride=0x10: addresses 0,0x10,0x20 accepted.
- Wrap and width:
  - Setup: x_max=1, y_max=0, x_stride=0xFFFF, y_stride=0.
  - Required: addresses 0,0xFFFF accepted, confirming x_stride zero-extension.
  - Setup: y_stride=0xFFFFFFF0, x_max=0, y_max=1.
  - Required: addresses 0,0xFFFFFFF0 accepted.
- Reset and start guards:
  - Assert rst_n=0 mid-row: all outputs go to 0 immediately.
  - start during RUN: ignored; the frame continues with the original configuration.
